boot_run_ctrl: RTL
==================

Name: boot_run_ctrl

Overview:
- Synthesizable replacement for the bench-side preload/run/readback sequence around the cpu core; generalised to N_CH external memory channels.
- Accepts commands to stream words into any channel, release cpu enable, detect the custom STOP opcode, count cycles, and stream back a window of any channel.
- Sits between a host/debug stream interface and the cpu's per-memory external access ports (addr/wen/ren/wdata/rdata).

Parameters:
- DATA_W, 64, memory word width.
- ADDR_W, 64, byte address width of each channel port.
- N_CH, 2, number of memory channels; ch0 = imem, ch1 = dmem.
- LEN_W, 16, width of word-count field.
- STOP_OPC, 7'b1111110, opcode value in instr[6:0] that ends RUN.
- TIMEOUT, 100000, RUN watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=LOAD, 1=RUN, 2=DUMP, 3=reserved (accepted, no-op).
- cmd_ch  in  $clog2(N_CH) (min 1)  target channel.
- cmd_base  in  ADDR_W  start byte address.
- cmd_len  in  LEN_W  word count; 0 means no transfers.
- in_valid / in_ready / in_data  in/out/in  1/1/DATA_W  LOAD data stream.
- out_valid / out_ready / out_data / out_last  out/in/out/out  1/1/DATA_W/1  DUMP data stream.
- mem_wen, mem_ren  out  N_CH  per-channel strobes.
- mem_addr  out  N_CH*ADDR_W  per-channel address, packed with ch0 in the LSBs.
- mem_wdata  out  N_CH*DATA_W  per-channel write data.
- mem_rdata  in  N_CH*DATA_W  per-channel read data, valid one cycle after ren.
- cpu_enable  out  1  cpu run enable.
- instr  in  32  cpu fetched instruction.
- stop_tag  out  4  instr[31:28] captured at STOP.
- cycle_cnt  out  32  cycles spent in the last RUN.
- done  out  1  one-cycle pulse at the end of any command.
- timeout_err  out  1  sticky; only with the optional feature.

Behaviour:
- Reset (arst_n=0 sampled at clk): state IDLE; all outputs 0 except cmd_ready=1; counters and address registers cleared.
- Reset mid-operation aborts immediately. Strobes are low in the reset cycle and no partial pulse is emitted.
- FSM states: IDLE, LOAD, RUN, DUMP, FIN.
- Transitions:
  - IDLE -> op state on cmd_valid && cmd_ready; cmd fields are latched.
  - len=0 for LOAD/DUMP, and op=3, go IDLE -> FIN directly.
  - FIN -> IDLE after one cycle; done=1 in FIN.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready cycle: mem_wen[ch]=1, mem_addr[ch]=base+8*k, mem_wdata[ch]=in_data, k=0..len-1. Strobes are combinational from the handshake.
  - Non-selected channels: strobes 0, addr/wdata 0.
  - After the len-th word: FIN.
- RUN:
  - cpu_enable=1 from the cycle after acceptance.
  - cycle_cnt cleared at acceptance and incremented each RUN cycle. It saturates at 2^32-1, with no wrap.
  - First cycle with cpu_enable=1 and instr[6:0]==STOP_OPC: capture stop_tag, cpu_enable=0 the next cycle, FIN.
  - That STOP cycle is counted.
- DUMP:
  - Issue mem_ren[ch] with addr=base+8*k.
  - Returned data goes into a 2-entry output skid FIFO.
  - A read issues only if (FIFO occupancy + reads in flight) < 2.
  - out_valid = FIFO non-empty; out_last marks word len-1.
  - out_data must hold stable while out_valid && !out_ready.
  - FIN after the last word handshakes.
- Address arithmetic is modulo 2^ADDR_W; wrap is permitted and not flagged.
- LOAD and DUMP never assert strobes on two channels in the same cycle.
- cmd_valid is ignored outside IDLE, with no queueing.

Optional Feature:
- Macro: BOOT_RUN_WATCHDOG_EN.
- Defined:
  - In RUN, if cycle_cnt reaches TIMEOUT without STOP: cpu_enable=0, timeout_err=1 (sticky until reset), stop_tag=4'hF, FIN.
  - A STOP in the same cycle as the timeout wins: normal completion, no error.
- Undefined: RUN waits indefinitely; the timeout_err port is absent.

Test Plan:
- LOAD ch0, base 0, len 4, data 1..4, in_valid toggling every other cycle -> ch0 writes at addr 0,8,16,24 with data 1..4 only on handshake cycles; ch1 silent; done pulse once.
- DUMP ch1, base 0x118, len 3, memory model holding 20,21,22, out_ready low for 5 cycles mid-burst -> out_data 20,21,22 in order, none lost or duplicated, out_last on 22, at most 2 ren ahead of the consumer.
- RUN with instr=0x5000007E presented after 37 enabled cycles -> stop_tag=5, cycle_cnt=38, cpu_enable low the next cycle.
- LOAD len 0 and op=3 -> done the next cycle, no strobes.
- Assert arst_n=0 during a DUMP with a word pending on out -> next cycle out_valid=0, cmd_ready=1, no done pulse.
- With BOOT_RUN_WATCHDOG_EN and TIMEOUT=50, no STOP -> cpu_enable drops after 50 cycles, timeout_err=1, stop_tag=F.

Source files
------------

// File: rtl/boot_run_ctrl.sv
// boot_run_ctrl: host-side preload / run / readback sequencer for the cpu core.
// LOAD streams words into one of N_CH memory channels, RUN releases cpu_enable
// until the STOP opcode is fetched, and DUMP streams a window of a channel back
// through a 2-entry skid FIFO.
// Optional feature macro: BOOT_RUN_WATCHDOG_EN adds a RUN watchdog (TIMEOUT
// parameter and the sticky timeout_err output).
module boot_run_ctrl #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64,
   parameter int N_CH = 2,
   parameter int LEN_W = 16,
   parameter logic [6:0] STOP_OPC = 7'b1111110,
`ifdef BOOT_RUN_WATCHDOG_EN
   parameter int TIMEOUT = 100000,
`endif
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [CH_W-1:0]          cmd_ch,
   input  logic [ADDR_W-1:0]        cmd_base,
   input  logic [LEN_W-1:0]         cmd_len,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   output logic [N_CH-1:0]          mem_wen,
   output logic [N_CH-1:0]          mem_ren,
   output logic [N_CH*ADDR_W-1:0]   mem_addr,
   output logic [N_CH*DATA_W-1:0]   mem_wdata,
   input  logic [N_CH*DATA_W-1:0]   mem_rdata,
   output logic                     cpu_enable,
   input  logic [31:0]              instr,
   output logic [3:0]               stop_tag,
   output logic [31:0]              cycle_cnt,
   output logic                     done
`ifdef BOOT_RUN_WATCHDOG_EN
   ,
   output logic                     timeout_err
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP, S_FIN} state_t;

   localparam logic [31:0] CNT_MAX = '1;
`ifdef BOOT_RUN_WATCHDOG_EN
   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT);
`endif

   // Cycle counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? v : v + 32'd1;
   endfunction

   // Byte address of word k from the base; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [LEN_W-1:0] k);
      return b + (ADDR_W'(k) << 3);
   endfunction

   state_t              state;
   logic [CH_W-1:0]     ch;
   logic [ADDR_W-1:0]   base;
   logic [LEN_W-1:0]    len;
   logic [LEN_W-1:0]    idx;
   logic [ADDR_W-1:0]   addr_cur;
   logic [31:0]         cnt_nxt;

   // Skid FIFO state; vld_p1/last_p1 track the read issued last cycle.
   logic [DATA_W-1:0]   fifo_data [2];
   logic [1:0]          fifo_last;
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          count;
   logic                vld_p1;
   logic                last_p1;
   logic [DATA_W-1:0]   rdata_sel;

   logic                ld_fire;
   logic                rd_fire;
   logic                pop;
   logic                is_last_idx;

   assign addr_cur    = word_addr(base, idx);
   assign cnt_nxt     = sat_inc(cycle_cnt);
   assign is_last_idx = (idx == len - LEN_W'(1));

   // Strobes are gated by arst_n so nothing fires in a reset cycle.
   assign ld_fire = arst_n && in_ready && in_valid;
   assign rd_fire = arst_n && (state == S_DUMP) && (idx < len) &&
                    (({1'b0, count} + {2'b00, vld_p1}) < 3'd2);

   assign out_valid = (count != 2'd0);
   assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
   assign out_last  = out_valid && fifo_last[rd_ptr];
   assign pop       = out_valid && out_ready;

   // Route the active strobe, address and write data to the selected channel only.
   always_comb begin
      mem_wen   = '0;
      mem_ren   = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      rdata_sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (ch == CH_W'(i)) begin
            rdata_sel = mem_rdata[i*DATA_W +: DATA_W];
            if (ld_fire) begin
               mem_wen[i]                    = 1'b1;
               mem_addr[i*ADDR_W +: ADDR_W]  = addr_cur;
               mem_wdata[i*DATA_W +: DATA_W] = in_data;
            end
            if (rd_fire) begin
               mem_ren[i]                   = 1'b1;
               mem_addr[i*ADDR_W +: ADDR_W] = addr_cur;
            end
         end
      end
   end

   // Capture returned read data into the skid FIFO one cycle after ren.
   always_ff @(posedge clk) begin
      if (vld_p1) begin
         fifo_data[wr_ptr] <= rdata_sel;
         fifo_last[wr_ptr] <= last_p1;
      end
   end

   // Main sequencer FSM with registered handshake / status outputs.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state      <= S_IDLE;
         cmd_ready  <= 1'b1;
         in_ready   <= 1'b0;
         cpu_enable <= 1'b0;
         done       <= 1'b0;
         stop_tag   <= 4'h0;
         cycle_cnt  <= 32'd0;
         ch         <= '0;
         base       <= '0;
         len        <= '0;
         idx        <= '0;
         count      <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         vld_p1     <= 1'b0;
         last_p1    <= 1'b0;
`ifdef BOOT_RUN_WATCHDOG_EN
         timeout_err <= 1'b0;
`endif
      end else begin
         done    <= 1'b0;
         vld_p1  <= rd_fire;
         last_p1 <= rd_fire && is_last_idx;
         count   <= count + {1'b0, vld_p1} - {1'b0, pop};
         if (vld_p1) wr_ptr <= ~wr_ptr;
         if (pop)    rd_ptr <= ~rd_ptr;

         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  ch        <= cmd_ch;
                  base      <= cmd_base;
                  len       <= cmd_len;
                  idx       <= '0;
                  case (cmd_op)
                     2'd0: begin
                        if (cmd_len == '0) begin
                           state <= S_FIN;
                           done  <= 1'b1;
                        end else begin
                           state    <= S_LOAD;
                           in_ready <= 1'b1;
                        end
                     end
                     2'd1: begin
                        state      <= S_RUN;
                        cpu_enable <= 1'b1;
                        cycle_cnt  <= 32'd0;
                     end
                     2'd2: begin
                        if (cmd_len == '0) begin
                           state <= S_FIN;
                           done  <= 1'b1;
                        end else begin
                           state <= S_DUMP;
                        end
                     end
                     default: begin
                        state <= S_FIN;
                        done  <= 1'b1;
                     end
                  endcase
               end
            end
            S_LOAD: begin
               if (ld_fire) begin
                  idx <= idx + LEN_W'(1);
                  if (is_last_idx) begin
                     in_ready <= 1'b0;
                     state    <= S_FIN;
                     done     <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               cycle_cnt <= cnt_nxt;
               if (cpu_enable && (instr[6:0] == STOP_OPC)) begin
                  stop_tag   <= instr[31:28];
                  cpu_enable <= 1'b0;
                  state      <= S_FIN;
                  done       <= 1'b1;
               end
`ifdef BOOT_RUN_WATCHDOG_EN
               else if (cnt_nxt >= TIMEOUT_LIM) begin
                  stop_tag    <= 4'hF;
                  timeout_err <= 1'b1;
                  cpu_enable  <= 1'b0;
                  state       <= S_FIN;
                  done        <= 1'b1;
               end
`endif
            end
            S_DUMP: begin
               if (rd_fire) idx <= idx + LEN_W'(1);
               if (pop && fifo_last[rd_ptr]) begin
                  state <= S_FIN;
                  done  <= 1'b1;
               end
            end
            S_FIN: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
